// File: rtl/pacman_move_ctrl_pkg.sv
// Shared definitions for the Pac-Man movement controller and the map
// address helper.
//   - Direction indices into the {U,D,L,R} lookup/button vectors.
//   - FSM state encoding of the per-frame lookup sequencer.
//   - Default screen geometry constants.
package pacman_move_ctrl_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SPRITE_EDGE = 22;

    // Bit positions inside 4-bit {U,D,L,R} vectors.
    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_L = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_U = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_QL     = 3'd1,
        ST_QR     = 3'd2,
        ST_QU     = 3'd3,
        ST_QD     = 3'd4,
        ST_CAPD   = 3'd5,
        ST_UPDATE = 3'd6
    } moveState_t;

endpackage

// File: rtl/pacman_map_addr.sv
// Combinational neighbour-address generator for the boolean map.
// Ports:
//   x, y      sprite position
//   dir       neighbour direction (DIR_R/L/D/U)
//   addr      row-major map address of the neighbour pixel, 0 when out of bounds
//   inBounds  1 when the neighbour lies inside the movement area
module pacman_map_addr
    import pacman_move_ctrl_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int SPRITE = SPRITE_EDGE,
    parameter int ADDR_W = 19
) (
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic [1:0]        dir,
    output logic [ADDR_W-1:0] addr,
    output logic              inBounds
);

    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [9:0]        X_MAX   = 10'(WIDTH - SPRITE);
    localparam logic [8:0]        Y_MAX   = 9'(HEIGHT - SPRITE);

    logic [ADDR_W-1:0] colA;
    logic [ADDR_W-1:0] rowA;

    always_comb begin
        colA     = ADDR_W'(x);
        rowA     = ADDR_W'(y);
        inBounds = 1'b0;
        case (dir)
            DIR_L: begin
                inBounds = (x != 10'd0);
                colA     = ADDR_W'(x) - ONE_A;
            end
            DIR_R: begin
                inBounds = (x < X_MAX);
                colA     = ADDR_W'(x) + ONE_A;
            end
            DIR_U: begin
                inBounds = (y != 9'd0);
                rowA     = ADDR_W'(y) - ONE_A;
            end
            DIR_D: begin
                inBounds = (y < Y_MAX);
                rowA     = ADDR_W'(y) + ONE_A;
            end
            default: ;
        endcase
        // Out-of-bounds neighbours would wrap; never put such an address on the bus.
        addr = inBounds ? (colA + WIDTH_A * rowA) : '0;
    end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller. Time-multiplexes the single boolean-map RAM
// port to fetch the four neighbour cells once per frame, then applies one
// movement step, and owns the sprite position and title-screen flag.
// Ports:
//   clk         system / map RAM clock
//   reset       synchronous active-low reset
//   frame_tick  end-of-frame level; rising edge starts a lookup sequence
//   btn_u/d/l/r direction buttons (level), latched at sequence start
//   btn_c       start button, clears start_game
//   map_addr    map read address (0 when idle or neighbour out of bounds)
//   map_data    map read data, one cycle after map_addr
//   pos_x/pos_y sprite position
//   allowed     {U,D,L,R} results of the last completed sequence
//   busy        lookup sequence in progress
//   move_done   one-cycle pulse in the position-commit cycle
//   overrun     sticky: a tick edge arrived while busy
//   start_game  title screen active
module pacman_move_ctrl
    import pacman_move_ctrl_pkg::*;
#(
    parameter int WIDTH   = SCREEN_W,
    parameter int HEIGHT  = SCREEN_H,
    parameter int SPRITE  = SPRITE_EDGE,
    parameter int START_X = 310,
    parameter int START_Y = 230,
    parameter int ADDR_W  = 19,
    parameter int MAP_DW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              btn_c,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [MAP_DW-1:0] map_data,
    output logic [9:0]        pos_x,
    output logic [8:0]        pos_y,
    output logic [3:0]        allowed,
    output logic              busy,
    output logic              move_done,
    output logic              overrun,
    output logic              start_game
);

    moveState_t        state;
    moveState_t        stateNext;
    logic              tickPrev;
    logic              tickEdge;
    logic [3:0]        btnLat;
    logic [3:0]        hitLat;
    logic              reqInB_p0;
    logic              issueVld;
    logic [1:0]        issueDir;
    logic [ADDR_W-1:0] calcAddr;
    logic              calcInB;
    logic              hit;
    logic [9:0]        xNext;
    logic [8:0]        yNext;

    assign tickEdge  = frame_tick & ~tickPrev;
    assign busy      = (state != ST_IDLE);
    assign move_done = (state == ST_UPDATE);
    // The in-bounds flag travels one cycle behind its address, alongside the RAM latency.
    assign hit       = (map_data != '0) & reqInB_p0;

    pacman_map_addr #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .SPRITE (SPRITE),
        .ADDR_W (ADDR_W)
    ) uMapAddr (
        .x        (pos_x),
        .y        (pos_y),
        .dir      (issueDir),
        .addr     (calcAddr),
        .inBounds (calcInB)
    );

    always_comb begin
        stateNext = state;
        issueVld  = 1'b0;
        issueDir  = DIR_L;
        case (state)
            ST_IDLE:   if (tickEdge) stateNext = ST_QL;
            ST_QL: begin
                issueVld  = 1'b1;
                issueDir  = DIR_L;
                stateNext = ST_QR;
            end
            ST_QR: begin
                issueVld  = 1'b1;
                issueDir  = DIR_R;
                stateNext = ST_QU;
            end
            ST_QU: begin
                issueVld  = 1'b1;
                issueDir  = DIR_U;
                stateNext = ST_QD;
            end
            ST_QD: begin
                issueVld  = 1'b1;
                issueDir  = DIR_D;
                stateNext = ST_CAPD;
            end
            ST_CAPD:   stateNext = ST_UPDATE;
            ST_UPDATE: stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
        map_addr = issueVld ? calcAddr : '0;
    end

    // Left beats right and up beats down; the two axes are independent.
    always_comb begin
        xNext = pos_x;
        yNext = pos_y;
        if (btnLat[DIR_L] && hitLat[DIR_L]) begin
            xNext = pos_x - 10'd1;
        end else if (btnLat[DIR_R] && hitLat[DIR_R]) begin
            xNext = pos_x + 10'd1;
        end
        if (btnLat[DIR_U] && hitLat[DIR_U]) begin
            yNext = pos_y - 9'd1;
        end else if (btnLat[DIR_D] && hitLat[DIR_D]) begin
            yNext = pos_y + 9'd1;
        end
    end

    // Control and position state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tickPrev   <= 1'b0;
            pos_x      <= 10'(START_X);
            pos_y      <= 9'(START_Y);
            allowed    <= 4'd0;
            overrun    <= 1'b0;
            start_game <= 1'b1;
        end else begin
            state    <= stateNext;
            tickPrev <= frame_tick;
            if (btn_c) begin
                start_game <= 1'b0;
            end
            if (tickEdge && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (state == ST_UPDATE) begin
                allowed <= hitLat;
                if (!start_game) begin
                    pos_x <= xNext;
                    pos_y <= yNext;
                end
            end
        end
    end

    // Lookup datapath: button latch and per-direction result capture
    always_ff @(posedge clk) begin
        reqInB_p0 <= issueVld & calcInB;
        if ((state == ST_IDLE) && tickEdge) begin
            btnLat <= {btn_u, btn_d, btn_l, btn_r};
        end
        case (state)
            ST_QR:   hitLat[DIR_L] <= hit;
            ST_QU:   hitLat[DIR_R] <= hit;
            ST_QD:   hitLat[DIR_U] <= hit;
            ST_CAPD: hitLat[DIR_D] <= hit;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
module tb_pacman_move_ctrl;

    logic        clk;
    logic        reset;
    logic        frame_tick;
    logic        btn_u, btn_d, btn_l, btn_r, btn_c;
    logic [3:0]  e0Btn, eEBtn;
    logic [18:0] blockAddr;

    logic [18:0] mAddr, zAddr, eAddr;
    logic [1:0]  mData, zData, eData;
    logic [9:0]  mX, zX, eX;
    logic [8:0]  mY, zY, eY;
    logic [3:0]  mAllow, zAllow, eAllow;
    logic        mBusy, zBusy, eBusy;
    logic        mDone, zDone, eDone;
    logic        mOvr, zOvr, eOvr;
    logic        mStart, zStart, eStart;

    int          errors = 0;
    int          checks = 0;
    int          doneCnt;
    int          doneAt;
    int          cnt;
    logic [18:0] aM [1:4];
    logic [18:0] aZ [1:4];
    logic [18:0] aE [1:4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] mapWord(input logic [18:0] a);
        return (a == blockAddr) ? 2'b00 : 2'b11;
    endfunction

    always @(posedge clk) begin
        mData <= mapWord(mAddr);
        zData <= mapWord(zAddr);
        eData <= mapWord(eAddr);
    end

    pacman_move_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
        .map_addr(mAddr), .map_data(mData), .pos_x(mX), .pos_y(mY),
        .allowed(mAllow), .busy(mBusy), .move_done(mDone), .overrun(mOvr),
        .start_game(mStart)
    );

    pacman_move_ctrl #(.START_X(0), .START_Y(0)) dutZero (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_u(e0Btn[3]), .btn_d(e0Btn[2]), .btn_l(e0Btn[1]), .btn_r(e0Btn[0]), .btn_c(btn_c),
        .map_addr(zAddr), .map_data(zData), .pos_x(zX), .pos_y(zY),
        .allowed(zAllow), .busy(zBusy), .move_done(zDone), .overrun(zOvr),
        .start_game(zStart)
    );

    pacman_move_ctrl #(.START_X(618), .START_Y(458)) dutEdge (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_u(eEBtn[3]), .btn_d(eEBtn[2]), .btn_l(eEBtn[1]), .btn_r(eEBtn[0]), .btn_c(btn_c),
        .map_addr(eAddr), .map_data(eData), .pos_x(eX), .pos_y(eY),
        .allowed(eAllow), .busy(eBusy), .move_done(eDone), .overrun(eOvr),
        .start_game(eStart)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts at a falling edge; raises frame_tick, drops it after holdCycles,
    // optionally pulses it again at reTickAt. Records the first four addresses.
    task automatic runSeq(input int holdCycles, input int reTickAt, input int cycles);
        doneCnt = 0;
        doneAt  = -1;
        frame_tick = 1'b1;
        for (int c = 1; c <= cycles; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                aM[c] = mAddr;
                aZ[c] = zAddr;
                aE[c] = eAddr;
            end
            if (mDone) begin
                doneCnt++;
                if (doneAt < 0) doneAt = c;
            end
            if (c == holdCycles) frame_tick = 1'b0;
            if (reTickAt > 0 && c == reTickAt) frame_tick = 1'b1;
            if (reTickAt > 0 && c == reTickAt + 1) frame_tick = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; frame_tick = 1'b0;
        btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
        e0Btn = 4'd0; eEBtn = 4'd0;
        blockAddr = '1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_x", 32'(mX), 32'd310);
        check("rst_y", 32'(mY), 32'd230);
        check("rst_start", 32'(mStart), 32'd1);
        check("rst_busy", 32'(mBusy), 32'd0);
        check("rst_ovr", 32'(mOvr), 32'd0);
        check("rst_allow", 32'(mAllow), 32'd0);
        check("rst_addr", 32'(mAddr), 32'd0);
        check("rst_done", 32'(mDone), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("start_hold", 32'(mStart), 32'd1);
        btn_c = 1'b1;
        @(negedge clk);
        btn_c = 1'b0;
        check("start_clr", 32'(mStart), 32'd0);
        check("start_clr_z", 32'(zStart), 32'd0);
        check("start_clr_e", 32'(eStart), 32'd0);

        // Blocked right
        blockAddr = 19'd147511;
        btn_r = 1'b1;
        runSeq(1, 0, 10);
        check("blk_x", 32'(mX), 32'd310);
        check("blk_y", 32'(mY), 32'd230);
        check("blk_allow", 32'(mAllow), 32'hE);
        check("blk_done", 32'(doneCnt), 32'd1);

        // Move right on open map
        blockAddr = '1;
        runSeq(1, 0, 10);
        check("mr_aL", 32'(aM[1]), 32'd147509);
        check("mr_aR", 32'(aM[2]), 32'd147511);
        check("mr_aU", 32'(aM[3]), 32'd146870);
        check("mr_aD", 32'(aM[4]), 32'd148150);
        check("mr_doneAt", 32'(doneAt), 32'd6);
        check("mr_doneCnt", 32'(doneCnt), 32'd1);
        check("mr_x", 32'(mX), 32'd311);
        check("mr_y", 32'(mY), 32'd230);
        check("mr_allow", 32'(mAllow), 32'hF);
        check("mr_busy", 32'(mBusy), 32'd0);

        // Priority and diagonal: left beats right, down applied too
        btn_l = 1'b1; btn_d = 1'b1;
        runSeq(1, 0, 10);
        check("dg_x", 32'(mX), 32'd310);
        check("dg_y", 32'(mY), 32'd231);

        // Edges at (0,0) and (618,458)
        btn_l = 1'b0; btn_d = 1'b0; btn_r = 1'b0;
        e0Btn = 4'b1010;
        eEBtn = 4'b0101;
        runSeq(1, 0, 10);
        check("z_aL", 32'(aZ[1]), 32'd0);
        check("z_aR", 32'(aZ[2]), 32'd1);
        check("z_aU", 32'(aZ[3]), 32'd0);
        check("z_aD", 32'(aZ[4]), 32'd640);
        check("z_x", 32'(zX), 32'd0);
        check("z_y", 32'(zY), 32'd0);
        check("z_allow", 32'(zAllow), 32'b0101);
        check("e_aL", 32'(aE[1]), 32'd293737);
        check("e_aR", 32'(aE[2]), 32'd0);
        check("e_aU", 32'(aE[3]), 32'd293098);
        check("e_aD", 32'(aE[4]), 32'd0);
        check("e_x", 32'(eX), 32'd618);
        check("e_y", 32'(eY), 32'd458);
        check("e_allow", 32'(eAllow), 32'b1010);
        check("edge_busy", 32'({zBusy, eBusy, zDone, eDone}), 32'd0);
        check("edge_ovr", 32'({zOvr, eOvr}), 32'd0);
        check("idle_x", 32'(mX), 32'd310);
        check("idle_y", 32'(mY), 32'd231);
        e0Btn = 4'd0;
        eEBtn = 4'd0;

        // Long-high tick: exactly one move, no overrun
        btn_r = 1'b1;
        runSeq(20, 0, 30);
        check("long_done", 32'(doneCnt), 32'd1);
        check("long_x", 32'(mX), 32'd311);
        check("long_ovr", 32'(mOvr), 32'd0);

        // Second tick edge during Q_U
        runSeq(1, 3, 25);
        check("ovr_flag", 32'(mOvr), 32'd1);
        check("ovr_done", 32'(doneCnt), 32'd1);
        check("ovr_x", 32'(mX), 32'd312);

        // Reset during Q_R
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(mBusy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mr_rst_busy", 32'(mBusy), 32'd0);
        check("mr_rst_done", 32'(mDone), 32'd0);
        check("mr_rst_addr", 32'(mAddr), 32'd0);
        check("mr_rst_x", 32'(mX), 32'd310);
        check("mr_rst_y", 32'(mY), 32'd230);
        check("mr_rst_ovr", 32'(mOvr), 32'd0);
        check("mr_rst_start", 32'(mStart), 32'd1);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mDone) cnt++;
        end
        check("mr_rst_nodone", 32'(cnt), 32'd0);
        check("mr_rst_x2", 32'(mX), 32'd310);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
- Sequences the single shared boolean-map RAM port to do the four per-frame collision lookups (left, right, up, down), one address per cycle; replaces four duplicated map RAMs.
- Owns the Pac-Man sprite position register and the title-screen flag.
- Applies one movement step per frame, gated by buttons and lookup results.
- Sits between the VGA timing generator (frame tick), the board buttons and the boolean-map VGARAM instance.

Parameters:
- WIDTH, 640: screen width in pixels; also the row stride of the map address.
- HEIGHT, 480: screen height in pixels.
- SPRITE, 22: sprite edge in pixels; used for the right/bottom bounds.
- START_X, 310: reset x position.
- START_Y, 230: reset y position.
- ADDR_W, 19: map address width.
- MAP_DW, 2: map data width.

Ports:
- clk  in  1  system clock (the map RAM clock)
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  screenEnd, synchronous to clk; may be high for more than one cycle
- btn_u, btn_d, btn_l, btn_r  in  1 each  direction buttons, level
- btn_c  in  1  start button
- map_addr  out  ADDR_W  boolean-map read address
- map_data  in  MAP_DW  map read data, valid 1 cycle after map_addr
- pos_x  out  10  sprite x
- pos_y  out  9  sprite y
- allowed  out  4  last lookup results {U,D,L,R} = [3:0]
- busy  out  1  sequence in progress
- move_done  out  1  one-cycle pulse when the position update is committed
- overrun  out  1  sticky: a tick arrived while busy
- start_game  out  1  title screen active

Behaviour:
- Reset (reset==0 at a clk edge):
  - pos_x=START_X, pos_y=START_Y.
  - start_game=1; state=IDLE; allowed=0; busy=0; move_done=0; overrun=0; map_addr=0.
  - Applies mid-sequence too: any in-flight lookup is discarded.
- Tick detection: the sequence starts on the rising edge of frame_tick, detected via a registered copy. A long-high tick starts exactly one sequence.
- Button latching: btn_u/d/l/r are latched on the start cycle and held for the whole sequence.
- FSM, one state per cycle:
  - IDLE: on tick edge, latch buttons, go to Q_L, busy=1.
  - Q_L: map_addr = (x-1) + WIDTH*y.
  - Q_R: map_addr = (x+1) + WIDTH*y; capture L.
  - Q_U: map_addr = x + WIDTH*(y-1); capture R.
  - Q_D: map_addr = x + WIDTH*(y+1); capture U.
  - CAP_D: capture D.
  - UPDATE: commit position, move_done=1, back to IDLE, busy=0.
  - Tick edge to move_done is 6 cycles; next tick accepted in the cycle after UPDATE.
- Address arithmetic: computed at ADDR_W bits, unsigned. Boundary cases are never issued as wrapped addresses: the address is forced to 0 and the result forced to 0.
- Allowed rule: a direction is allowed iff map_data != 0 and it is in bounds:
  - L needs x>0.
  - R needs x < WIDTH-SPRITE.
  - U needs y>0.
  - D needs y < HEIGHT-SPRITE.
- Update rule, applied in UPDATE:
  - Horizontal: if btn_l and L allowed then x-1; else if btn_r and R allowed then x+1. Left wins over right.
  - Vertical: if btn_u and U allowed then y-1; else if btn_d and D allowed then y+1. Up wins over down.
  - Horizontal and vertical apply in the same update, so a diagonal step is legal.
- Lookup status: allowed[3:0] is updated in UPDATE and held until the next UPDATE.
- start_game: cleared to 0 whenever btn_c==1 at any clk edge (not frame-gated). Only reset sets it again.
- Movement while start_game==1: lookups still run; position changes are suppressed.
- overrun: set when a tick edge occurs in any state other than IDLE; that tick is dropped. Cleared only by reset.

Decomposition:
- Shared package:
  - direction index constants DIR_R=0, DIR_L=1, DIR_D=2, DIR_U=3;
  - FSM state encoding;
  - default screen constants 640/480/22.
- Sub-module pacman_map_addr: combinational; (x, y, dir) -> addr plus in_bounds flag. Reused later for ghost movement controllers.

Test Plan:
- Reset: hold reset=0 for 2 clocks, release -> pos=(310,230), start_game=1, busy=0, overrun=0, allowed=0.
- Move right: all-ones map, btn_r=1, one tick -> map_addr sequence 640*230+309, +311, 640*229+310, 640*231+310 on consecutive cycles; move_done on cycle 6; pos_x=311; allowed=4'hF.
- Blocked right: map word at 640*230+311 = 0, btn_r, tick -> pos unchanged, allowed[0]=0, allowed[3:1]=3'b111.
- Priority and diagonal: btn_l, btn_r and btn_d all high, open map, tick -> pos=(309,231).
- Edges: pos forced to x=0,y=0 by start params, btn_l+btn_u, open map -> pos stays (0,0), allowed[1]=0, allowed[3]=0, no wrapped address issued. Repeat at x=618, y=458 with btn_r+btn_d -> no move.
- Timing faults:
  - frame_tick held high 20 cycles -> exactly one move.
  - Second tick edge during Q_U -> overrun=1, only one move.
  - reset=0 during Q_R -> next cycle state IDLE, pos=(310,230), no move_done.
